// File: rtl/rr_arbiter_8x3_if.sv
// Request/grant bundle between the requesters and rr_arbiter_8x3.
// master = requester side (drives req), slave = arbiter side (drives grants).
interface rr_arbiter_8x3_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_vld,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter_8x3.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant and 3-bit index.
// Optional hold-timeout with requester masking is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_8x3 #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_arbiter_8x3_if.slave   bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    logic [2:0]     ptr;
    logic [N-1:0]   gnt;
    logic [2:0]     gnt_idx;
    logic           gnt_vld;
    logic [N-1:0]   mask;
    logic [N-1:0]   cand;
    logic [2:0]     win;
    logic [2:0]     scan;
    logic           found;

    // A hold limit below 2 would leave no BUSY cycle before expiry.
    if (MAX_HOLD < 2) begin : g_max_hold_invalid
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

    logic [4:0]     hold_cnt;
    logic           timeout;
    logic [N-1:0]   mask_q;

    assign mask        = mask_q;
    assign bus.timeout = timeout;
`else
    assign mask        = '0;
    assign bus.timeout = 1'b0;
`endif

    assign cand = bus.req & ~mask;

    // First eligible requester scanning upward from ptr, wrapping mod 8.
    always_comb begin
        win   = '0;
        found = 1'b0;
        scan  = '0;
        for (int k = 0; k < N; k++) begin
            scan = ptr + 3'(k);
            if (!found && cand[scan]) begin
                win   = scan;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
            timeout  <= 1'b0;
            mask_q   <= '0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
            // A mask bit survives only while its requester keeps req high.
            mask_q  <= mask_q & bus.req;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt      <= '0;
                        gnt[win] <= 1'b1;
                        gnt_idx  <= win;
                        gnt_vld  <= 1'b1;
                        ptr      <= win + 3'd1;
                        state    <= BUSY;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                BUSY: begin
                    // Normal release wins over expiry on the same edge.
                    if (!bus.req[gnt_idx]) begin
                        gnt     <= '0;
                        gnt_idx <= '0;
                        gnt_vld <= 1'b0;
                        state   <= IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt == HOLD_LAST) begin
                        gnt             <= '0;
                        gnt_idx         <= '0;
                        gnt_vld         <= 1'b0;
                        state           <= IDLE;
                        timeout         <= 1'b1;
                        mask_q[gnt_idx] <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 5'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt;
    assign bus.gnt_idx = gnt_idx;
    assign bus.gnt_vld = gnt_vld;

endmodule

// File: tb/tb_rr_arbiter_8x3.sv
// Scoreboard bench for rr_arbiter_8x3: directed cases followed by random request traffic.
module tb_rr_arbiter_8x3;

`ifdef ARB_TIMEOUT_EN
    localparam int MAX_HOLD = 4;
    localparam bit TMO_EN   = 1'b1;
`else
    localparam int MAX_HOLD = 16;
    localparam bit TMO_EN   = 1'b0;
`endif

    logic clk;
    logic rst_n;

    rr_arbiter_8x3_if bus();

    rr_arbiter_8x3 #(.N(8), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected output record: {gnt[7:0], gnt_idx[2:0], gnt_vld, timeout}
    logic [12:0] exp_q[$];

    // Reference model state, in plain integer terms.
    bit       m_busy;
    int       m_owner;
    int       m_ptr;
    int       m_hold;
    bit [7:0] m_mask;
    bit       m_tmo;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_hold  = 0;
        m_mask  = '0;
        m_tmo   = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] r);
        bit got;
        m_tmo = 1'b0;
        if (TMO_EN) m_mask = m_mask & r;
        if (!m_busy) begin
            got = 1'b0;
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (!got && r[c] && !m_mask[c]) begin
                    got     = 1'b1;
                    m_busy  = 1'b1;
                    m_owner = c;
                    m_ptr   = (c + 1) % 8;
                    m_hold  = 0;
                end
            end
        end else if (!r[m_owner]) begin
            m_busy = 1'b0;
        end else if (TMO_EN && m_hold == MAX_HOLD - 1) begin
            m_busy          = 1'b0;
            m_tmo           = 1'b1;
            m_mask[m_owner] = 1'b1;
        end else begin
            m_hold++;
        end
    endfunction

    function automatic logic [12:0] model_out();
        logic [7:0] g;
        logic [2:0] i;
        g = '0;
        i = '0;
        if (m_busy) begin
            g[m_owner] = 1'b1;
            i = 3'(m_owner);
        end
        return {g, i, m_busy, m_tmo};
    endfunction

    // Stimulus side: advance the model on each active edge and queue the expectation.
    always @(posedge clk) begin
        if (rst_n) begin
            model_step(bus.req);
            exp_q.push_back(model_out());
        end
    end

    // Monitor side: compare DUT outputs against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [12:0] e;
            e = exp_q.pop_front();
            chk("sb_outputs", {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout}, e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("reset_outputs", {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout}, 13'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.req = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Single request, grant after one edge, release after one edge.
        bus.req = 8'h08;
        tick();
        chk("t1_gnt", bus.gnt, 8'h08);
        chk("t1_idx", bus.gnt_idx, 3);
        chk("t1_vld", bus.gnt_vld, 1);
        bus.req = 8'h00;
        tick();
        chk("t1_rel_gnt", bus.gnt, 8'h00);
        chk("t1_rel_vld", bus.gnt_vld, 0);

        // All requesting: strict rotation with one dead cycle between owners.
        do_reset();
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("t2_order", bus.gnt_idx, k % 8);
            chk("t2_vld", bus.gnt_vld, 1);
            tick();
            chk("t2_hold", bus.gnt_idx, k % 8);
            bus.req[k % 8] = 1'b0;
            tick();
            chk("t2_dead", bus.gnt_vld, 0);
            bus.req = 8'hFF;
        end
        bus.req = 8'h00;
        tick();

        // Pointer wrap from 6 through 7 to 0.
        do_reset();
        bus.req = 8'h20;
        tick();
        chk("t3_idx5", bus.gnt_idx, 5);
        bus.req = 8'h00;
        tick();
        bus.req = 8'h05;
        tick();
        chk("t3_wrap_idx0", bus.gnt_idx, 0);
        bus.req = 8'h04;
        tick();
        chk("t3_dead", bus.gnt_vld, 0);
        tick();
        chk("t3_idx2", bus.gnt_idx, 2);
        bus.req = 8'h00;
        tick();

        // Asynchronous reset in the middle of a grant.
        do_reset();
        bus.req = 8'h10;
        tick();
        chk("t4_gnt", bus.gnt, 8'h10);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("t4_async_gnt", bus.gnt, 8'h00);
        chk("t4_async_vld", bus.gnt_vld, 0);
        chk("t4_async_idx", bus.gnt_idx, 0);
        bus.req = 8'h30;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        chk("t4_after_idx", bus.gnt_idx, 4);
        chk("t4_after_gnt", bus.gnt, 8'h10);
        bus.req = 8'h00;
        tick();

`ifdef ARB_TIMEOUT_EN
        // Hold expiry, masking and re-admission after a low sample.
        do_reset();
        bus.req = 8'h24;
        tick();
        chk("t5_idx2", bus.gnt_idx, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_held", bus.gnt_idx, 2);
            chk("t5_no_tmo", bus.timeout, 0);
        end
        tick();
        chk("t5_revoke_gnt", bus.gnt, 8'h00);
        chk("t5_timeout", bus.timeout, 1);
        tick();
        chk("t5_next_idx5", bus.gnt_idx, 5);
        chk("t5_tmo_pulse", bus.timeout, 0);
        bus.req = 8'h04;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_masked", bus.gnt_vld, 0);
        end
        bus.req = 8'h00;
        tick();
        bus.req = 8'h04;
        tick();
        chk("t5_regrant", bus.gnt_idx, 2);
        chk("t5_regrant_vld", bus.gnt_vld, 1);
        bus.req = 8'h00;
        tick();
`else
        // Without the timeout feature a grant is held indefinitely.
        do_reset();
        bus.req = 8'h24;
        tick();
        chk("t5_idx2", bus.gnt_idx, 2);
        for (int i = 0; i < 22; i++) begin
            tick();
            chk("t5_long_hold", {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout}, {8'h04, 3'd2, 1'b1, 1'b0});
        end
        bus.req = 8'h00;
        tick();
`endif

        // Idle: nothing requested, everything stays zero.
        bus.req = 8'h00;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t6_idle", {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout}, 13'h0);
        end

        // Random traffic checked by the scoreboard.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(7, 0))
                0:       bus.req = 8'($urandom);
                1, 2:    bus.req[$urandom_range(7, 0)] = ~bus.req[$urandom_range(7, 0)];
                default: ;
            endcase
            if (bus.gnt_vld && $urandom_range(5, 0) == 0) bus.req[bus.gnt_idx] = 1'b0;
            tick();
        end
        bus.req = 8'h00;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
